xnor_popcount_acc: RTL and testbench

Accumulates bitwise XNOR results over a multi-beat binary vector and produces the signed ±1 dot product of that vector. It sits directly downstream of the XNOR stage in the binary-MAC datapath. It consumes one BW-bit XNOR word per beat and emits one result per vector, marked by a last flag. The optional threshold path binarizes the result for the next layer.

---
 rtl/xnor_acc_pkg.sv | 20 ++
 rtl/xnor_popcount_acc_popcount.sv | 38 +++
 rtl/xnor_popcount_acc.sv | 175 +++++++++++++++++
 tb/tb_xnor_popcount_acc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/xnor_acc_pkg.sv
// -----------------------------------------------------------------------------
// xnor_acc_pkg
// Shared definitions for the XNOR popcount accumulator:
//   - default word width (BW_DEF) and accumulator/result width (ACC_W_DEF)
//   - acc_t: signed result type at the default accumulator width
//   - out_state_e: output-side holding state (EMPTY / FULL)
// -----------------------------------------------------------------------------
package xnor_acc_pkg;

  localparam int BW_DEF    = 8;
  localparam int ACC_W_DEF = 16;

  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/xnor_popcount_acc_popcount.sv
// -----------------------------------------------------------------------------
// popcount
// Purely combinational population count, built as a balanced adder tree by
// recursively splitting the word in halves. This keeps the depth at
// log2(BW) adders, so wide words (up to 64 bits) stay in one stage.
// Ports:
//   a_i    [BW-1:0]             input word
//   cnt_o  [$clog2(BW+1)-1:0]   number of set bits in a_i (0..BW)
// -----------------------------------------------------------------------------
module popcount #(
  parameter int BW = 8
) (
  input  logic [BW-1:0]             a_i,
  output logic [$clog2(BW+1)-1:0]   cnt_o
);

  localparam int CW = $clog2(BW+1);

  generate
    if (BW == 1) begin : g_leaf
      assign cnt_o = a_i;
    end else begin : g_split
      localparam int LO  = BW / 2;
      localparam int HI  = BW - LO;
      localparam int LCW = $clog2(LO+1);
      localparam int HCW = $clog2(HI+1);

      logic [LCW-1:0] cnt_lo;
      logic [HCW-1:0] cnt_hi;

      popcount #(.BW(LO)) u_lo (.a_i(a_i[LO-1:0]),  .cnt_o(cnt_lo));
      popcount #(.BW(HI)) u_hi (.a_i(a_i[BW-1:LO]), .cnt_o(cnt_hi));

      assign cnt_o = CW'(cnt_lo) + CW'(cnt_hi);
    end
  endgenerate

endmodule

// File: rtl/xnor_popcount_acc.sv
// -----------------------------------------------------------------------------
// xnor_popcount_acc
// Accumulates XNOR words over a multi-beat vector and emits the signed +/-1
// dot product (2*matches - bits) once per vector, on the beat flagged last.
// Accumulation of the next vector continues while a result is held, so the
// input only stalls when a result is pending and downstream is not ready.
//
// Optional feature: define XNOR_ACC_THRESH_EN to add i_Thresh / o_Bit, which
// register a binarized result (sum >= i_Thresh, signed) alongside o_Sum.
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-high reset
//   i_valid   input beat valid
//   o_ready   block accepts a beat this cycle
//   i_A       XNOR word, 1 = match
//   i_last    beat is the last word of the vector
//   o_valid   result valid
//   i_ready   downstream accepts result
//   o_Sum     signed dot product
//   o_Ovf     accumulation overflow for this result
//   i_Thresh  signed threshold  (XNOR_ACC_THRESH_EN only)
//   o_Bit     binarized result  (XNOR_ACC_THRESH_EN only)
// -----------------------------------------------------------------------------
module xnor_popcount_acc
  import xnor_acc_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [BW-1:0]           i_A,
  input  logic                    i_last,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [ACC_W-1:0] o_Sum,
`ifdef XNOR_ACC_THRESH_EN
  input  logic signed [ACC_W-1:0] i_Thresh,
  output logic                    o_Bit,
`endif
  output logic                    o_Ovf
);

  localparam int PCW = $clog2(BW+1);

  // Dot product from the accumulated counts: 2*pop - bits, wrapped to ACC_W.
  function automatic logic signed [ACC_W-1:0] dot_from_counts(
    input logic [ACC_W-1:0] pop_cnt,
    input logic [ACC_W-1:0] bit_cnt
  );
    logic [ACC_W-1:0] dbl;
    dbl = pop_cnt << 1;
    return $signed(dbl - bit_cnt);
  endfunction

  // The doubling drops pop_cnt's MSB; a set MSB there means the sum is wrong.
  function automatic logic shift_loses_msb(input logic [ACC_W-1:0] pop_cnt);
    return pop_cnt[ACC_W-1];
  endfunction

  out_state_e state_q, state_d;

  logic [ACC_W-1:0]        pop_acc_q;
  logic [ACC_W-1:0]        bit_acc_q;
  logic                    ovf_acc_q;

  logic signed [ACC_W-1:0] sum_q;
  logic                    ovf_q;

  logic [PCW-1:0]          pop;
  logic [ACC_W:0]          pop_ext;
  logic [ACC_W:0]          bit_ext;
  logic [ACC_W-1:0]        pop_acc_d;
  logic [ACC_W-1:0]        bit_acc_d;
  logic                    ovf_acc_d;
  logic signed [ACC_W-1:0] sum_d;
  logic                    ovf_d;
  logic                    accept;
  logic                    accept_last;

  // ---- stage 0: popcount + accumulate (single combinational stage) ----
  popcount #(.BW(BW)) u_popcount (
    .a_i   (i_A),
    .cnt_o (pop)
  );

  assign accept      = i_valid && o_ready;
  assign accept_last = accept && i_last;

  // One extra bit on each add exposes the carry out of the ACC_W accumulator.
  assign pop_ext   = {1'b0, pop_acc_q} + (ACC_W+1)'(pop);
  assign bit_ext   = {1'b0, bit_acc_q} + (ACC_W+1)'(BW);
  assign pop_acc_d = pop_ext[ACC_W-1:0];
  assign bit_acc_d = bit_ext[ACC_W-1:0];
  assign ovf_acc_d = ovf_acc_q | pop_ext[ACC_W] | bit_ext[ACC_W];

  assign sum_d = dot_from_counts(pop_acc_d, bit_acc_d);
  assign ovf_d = ovf_acc_d | shift_loses_msb(pop_acc_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_acc_q <= '0;
      bit_acc_q <= '0;
      ovf_acc_q <= 1'b0;
    end else if (accept) begin
      if (i_last) begin
        pop_acc_q <= '0;
        bit_acc_q <= '0;
        ovf_acc_q <= 1'b0;
      end else begin
        pop_acc_q <= pop_acc_d;
        bit_acc_q <= bit_acc_d;
        ovf_acc_q <= ovf_acc_d;
      end
    end
  end

  // ---- stage 1: result register (loaded by the accepted last beat) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept_last) begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef XNOR_ACC_THRESH_EN
  logic bit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_q <= 1'b0;
    end else if (accept_last) begin
      bit_q <= (sum_d >= i_Thresh);
    end
  end

  assign o_Bit = bit_q;
`endif

  // Output-side state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a new last beat always (re)fills; otherwise i_ready drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept_last) state_d = FULL;
      FULL:    if (accept_last) state_d = FULL;
               else if (i_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Outputs: o_ready depends only on state and i_ready, never on i_valid.
  always_comb begin
    o_valid = (state_q == FULL);
    o_ready = !o_valid || i_ready;
  end

  assign o_Sum = sum_q;
  assign o_Ovf = ovf_q;

endmodule

// File: tb/tb_xnor_popcount_acc.sv
module tb_xnor_popcount_acc;

  localparam int BW    = 8;
  localparam int ACC_W = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    i_valid;
  logic                    o_ready;
  logic [BW-1:0]           i_A;
  logic                    i_last;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [ACC_W-1:0] o_Sum;
  logic                    o_Ovf;
`ifdef XNOR_ACC_THRESH_EN
  logic signed [ACC_W-1:0] i_Thresh;
  logic                    o_Bit;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xnor_popcount_acc #(.BW(BW), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_A      (i_A),
    .i_last   (i_last),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_Sum    (o_Sum),
`ifdef XNOR_ACC_THRESH_EN
    .i_Thresh (i_Thresh),
    .o_Bit    (o_Bit),
`endif
    .o_Ovf    (o_Ovf)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one beat at a negedge; return at the following negedge with
  // i_valid dropped, so outputs reflect the edge that took the beat.
  task automatic beat(input logic [BW-1:0] a, input logic last);
    @(negedge clk);
    i_valid = 1'b1;
    i_A     = a;
    i_last  = last;
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  function automatic int sval(input logic signed [ACC_W-1:0] v);
    return int'(v);
  endfunction

  logic [BW-1:0] b2b_a [4];
  int            b2b_s [4];

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_A     = '0;
    i_last  = 1'b0;
    i_ready = 1'b1;
`ifdef XNOR_ACC_THRESH_EN
    i_Thresh = '0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_valid", o_valid, 0);
    chk("rst_sum",   sval(o_Sum), 0);
    chk("rst_ovf",   o_Ovf, 0);
    chk("rst_ready", o_ready, 1);

    // Single beat all matches -> +8
    beat(8'hFF, 1'b1);
    chk("single_valid", o_valid, 1);
    chk("single_sum",   sval(o_Sum), 8);
    chk("single_ovf",   o_Ovf, 0);
    @(negedge clk);
    chk("single_drain", o_valid, 0);

    // Three beats: 2*12 - 24 = 0, then single 00 -> -8
    beat(8'hF0, 1'b0);
    beat(8'h00, 1'b0);
    chk("multi_novalid", o_valid, 0);
    beat(8'hFF, 1'b1);
    chk("multi_sum", sval(o_Sum), 0);
    beat(8'h00, 1'b1);
    chk("neg_sum", sval(o_Sum), -8);
    @(negedge clk);

    // Stall: result held with i_ready=0, next vector's beats
    i_ready = 1'b0;
    chk("stall_ready0", o_ready, 1);
    beat(8'hFF, 1'b0);
    chk("stall_ready1", o_ready, 1);
    beat(8'hFF, 1'b1);              // 2*16 - 16 = 16
    chk("stall_valid", o_valid, 1);
    chk("stall_ready_lo", o_ready, 0);
    chk("stall_sum", sval(o_Sum), 16);
    i_valid = 1'b1;                 // offered while stalled: must not be taken
    i_A     = 8'h00;
    i_last  = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_hold_sum", sval(o_Sum), 16);
    chk("stall_hold_rdy", o_ready, 0);
    i_ready = 1'b1;                 // release: beat 00 accepted exactly once
    @(negedge clk);
    i_valid = 1'b0;
    chk("stall_release", o_valid, 0);
    beat(8'hFF, 1'b1);              // 2*8 - 16 = 0
    chk("stall_after_sum", sval(o_Sum), 0);
    @(negedge clk);

    // Back-to-back single-beat vectors, one result per cycle
    b2b_a = '{8'hFF, 8'h0F, 8'h00, 8'h03};
    b2b_s = '{8, 0, -8, -4};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_valid", o_valid, 1);
        chk($sformatf("b2b_sum%0d", i-1), sval(o_Sum), b2b_s[i-1]);
      end
      i_valid = 1'b1;
      i_A     = b2b_a[i];
      i_last  = 1'b1;
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk("b2b_sum3", sval(o_Sum), b2b_s[3]);
    @(negedge clk);
    chk("b2b_drain", o_valid, 0);

    // Overflow: 17 beats of FF with ACC_W=8. pop=bit=136 (0x88):
    // (0x88<<1)&0xFF = 0x10; 0x10 - 0x88 = 0x88 = -120
    for (int i = 0; i < 17; i++) beat(8'hFF, (i == 16));
    chk("ovf_flag", o_Ovf, 1);
    chk("ovf_sum",  sval(o_Sum), -120);
    beat(8'hFF, 1'b1);
    chk("ovf_clear", o_Ovf, 0);
    chk("ovf_next_sum", sval(o_Sum), 8);
    @(negedge clk);

`ifdef XNOR_ACC_THRESH_EN
    i_Thresh = '0;
    beat(8'h0F, 1'b1);              // 0
    chk("thr_zero", o_Bit, 1);
    beat(8'h1F, 1'b1);              // +2
    chk("thr_pos", o_Bit, 1);
    beat(8'h07, 1'b1);              // -2
    chk("thr_neg", o_Bit, 0);
    @(negedge clk);
`endif

    // Reset discards a held result
    i_ready = 1'b0;
    beat(8'hFF, 1'b1);
    chk("pre_rst_valid", o_valid, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_held_valid", o_valid, 0);
    chk("rst_held_sum", sval(o_Sum), 0);
    i_ready = 1'b1;

    // Reset mid-vector discards the partial vector
    beat(8'hFF, 1'b0);
    beat(8'hFF, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_valid", o_valid, 0);
    beat(8'h0F, 1'b1);
    chk("rst_mid_sum", sval(o_Sum), 0);
    chk("rst_mid_ovf", o_Ovf, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
